// File: rtl/lbist_pkg.sv
// lbist_pkg: shared types and constants for the logic-BIST sequencer.
// PRPG/MISR polynomials, seed and the sequencer state encoding.
package lbist_pkg;
    localparam int SIG_W = 16;
    localparam logic [SIG_W-1:0] LFSR_SEED = 16'hACE1;
    // taps at bits 0,2,3,5
    localparam logic [SIG_W-1:0] PRPG_TAPS = 16'h002D;
    localparam logic [SIG_W-1:0] MISR_POLY = 16'h1021;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_CAPTURE,
        S_UNLOAD,
        S_DONE
    } state_t;

    function automatic logic [SIG_W-1:0] prpg_step(
        input logic [SIG_W-1:0] p
    );
        return {^(p & PRPG_TAPS), p[SIG_W-1:1]};
    endfunction
endpackage

// File: rtl/lbist_if.sv
// lbist_if: control and scan-chain signals of the BIST sequencer.
// master = test-access side, slave = sequencer.
interface lbist_if #(
    parameter int PAT_W = 16
);
    logic                       start;
    logic                       abort;
    logic [PAT_W-1:0]           num_pat;
    logic                       scan_so;
    logic                       scan_si;
    logic                       SE;
    logic                       test_ce;
    logic                       busy;
    logic                       done;
    logic [PAT_W-1:0]           pat_cnt;
    logic [lbist_pkg::SIG_W-1:0] signature;

    modport master (
        output start, abort, num_pat, scan_so,
        input  scan_si, SE, test_ce, busy, done,
        input  pat_cnt, signature
    );

    modport slave (
        input  start, abort, num_pat, scan_so,
        output scan_si, SE, test_ce, busy, done,
        output pat_cnt, signature
    );
endinterface

// File: rtl/lbist_misr.sv
// lbist_misr: 16-bit multiple-input signature register, one input bit.
// clr has priority over en; contents hold when en is low.
module lbist_misr
    import lbist_pkg::*;
(
    input  logic             CK,
    input  logic             RN,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [SIG_W-1:0] sig
);
    logic [SIG_W-1:0] fold;

    assign fold = sig[SIG_W-1] ? MISR_POLY : '0;

    // compact one scan-out bit per enabled cycle
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= {sig[SIG_W-2:0], 1'b0} ^ fold
                 ^ {{(SIG_W-1){1'b0}}, din};
        end
    end
endmodule

// File: rtl/lbist_ctrl.sv
// lbist_ctrl: load/capture/unload sequencer for one full-scan chain.
// Inline PRPG drives scan-in; scan-out is folded into lbist_misr.
module lbist_ctrl
    import lbist_pkg::*;
#(
    parameter int CHAIN_LEN = 64,
    parameter int CAP_CYC   = 1,
    parameter int PAT_W     = 16
) (
    input logic  CK,
    input logic  RN,
    lbist_if.slave bus
);
    localparam int SH_W = $clog2(CHAIN_LEN);
    localparam int CC_W = $clog2(CAP_CYC + 1);
    localparam logic [SH_W-1:0] SH_LAST = SH_W'(CHAIN_LEN - 1);
    localparam logic [CC_W-1:0] CC_LAST = CC_W'(CAP_CYC - 1);
    localparam logic [PAT_W-1:0] PAT_MAX = '1;

    state_t           state;
    logic [SIG_W-1:0] prpg;
    logic [SIG_W-1:0] prpg_nx;
    logic [SH_W-1:0]  shift_cnt;
    logic [CC_W-1:0]  cap_cnt;
    logic [PAT_W-1:0] num_q;
    logic [PAT_W-1:0] pat_cnt;
    logic [PAT_W-1:0] pat_inc;
    logic             first;
    logic             se_q;
    logic             ce_q;
    logic             busy_q;
    logic             done_q;
    logic             si_q;
    logic             misr_clr;
    logic             misr_en;

    assign prpg_nx = prpg_step(prpg);
    assign pat_inc = (pat_cnt == PAT_MAX) ? pat_cnt
                                          : pat_cnt + PAT_W'(1);

    // new session (even an empty one) wipes the old signature
    assign misr_clr = (state == S_IDLE) & bus.start & ~bus.abort;
    // first load shifts out unknown chain contents, so it is masked
    assign misr_en = ~bus.abort
                   & (((state == S_SHIFT) & ~first)
                   | (state == S_UNLOAD));

    assign bus.SE      = se_q;
    assign bus.test_ce = ce_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.scan_si = si_q;
    assign bus.pat_cnt = pat_cnt;

    lbist_misr u_misr (
        .CK  (CK),
        .RN  (RN),
        .clr (misr_clr),
        .en  (misr_en),
        .din (bus.scan_so),
        .sig (bus.signature)
    );

    // session FSM with registered chain controls and PRPG
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state     <= S_IDLE;
            prpg      <= LFSR_SEED;
            shift_cnt <= '0;
            cap_cnt   <= '0;
            num_q     <= '0;
            pat_cnt   <= '0;
            first     <= 1'b1;
            se_q      <= 1'b0;
            ce_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            si_q      <= 1'b0;
        end else if (bus.abort) begin
            state     <= S_IDLE;
            shift_cnt <= '0;
            cap_cnt   <= '0;
            se_q      <= 1'b0;
            ce_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            si_q      <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        pat_cnt <= '0;
                        if (bus.num_pat != '0) begin
                            state     <= S_SHIFT;
                            num_q     <= bus.num_pat;
                            prpg      <= LFSR_SEED;
                            shift_cnt <= '0;
                            cap_cnt   <= '0;
                            first     <= 1'b1;
                            se_q      <= 1'b1;
                            ce_q      <= 1'b1;
                            busy_q    <= 1'b1;
                            si_q      <= LFSR_SEED[0];
                        end else begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    prpg <= prpg_nx;
                    si_q <= prpg_nx[0];
                    if (shift_cnt == SH_LAST) begin
                        shift_cnt <= '0;
                        state     <= S_CAPTURE;
                        se_q      <= 1'b0;
                    end else begin
                        shift_cnt <= shift_cnt + SH_W'(1);
                    end
                end
                S_CAPTURE: begin
                    if (cap_cnt == CC_LAST) begin
                        cap_cnt <= '0;
                        pat_cnt <= pat_inc;
                        first   <= 1'b0;
                        se_q    <= 1'b1;
                        if (pat_inc == num_q) begin
                            state <= S_UNLOAD;
                        end else begin
                            state <= S_SHIFT;
                        end
                    end else begin
                        cap_cnt <= cap_cnt + CC_W'(1);
                    end
                end
                S_UNLOAD: begin
                    prpg <= prpg_nx;
                    if (shift_cnt == SH_LAST) begin
                        shift_cnt <= '0;
                        state     <= S_DONE;
                        se_q      <= 1'b0;
                        ce_q      <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        si_q      <= 1'b0;
                    end else begin
                        shift_cnt <= shift_cnt + SH_W'(1);
                        si_q      <= prpg_nx[0];
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lbist_ctrl.sv
// tb_lbist_ctrl: scoreboard bench for the logic-BIST sequencer.
// Per-cycle chain controls and final signature come from a bench model.
module tb_lbist_ctrl;
    localparam int CL = 4;
    localparam int CC = 1;
    localparam int PW = 16;

    typedef struct packed {
        logic se;
        logic ce;
        logic busy;
        logic si;
        logic done;
    } obs_t;

    logic CK = 1'b0;
    logic RN = 1'b0;

    lbist_if #(.PAT_W(PW)) bus ();

    lbist_ctrl #(
        .CHAIN_LEN (CL),
        .CAP_CYC   (CC),
        .PAT_W     (PW)
    ) dut (
        .CK  (CK),
        .RN  (RN),
        .bus (bus)
    );

    always #5 CK = ~CK;

    int          n_cmp = 0;
    int          n_bad = 0;
    obs_t        exp_q[$];
    bit          so_q[$];
    logic [15:0] sig_exp;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr(input logic [15:0] p);
        return {p[0] ^ p[2] ^ p[3] ^ p[5], p[15:1]};
    endfunction

    function automatic logic [15:0] misr(input logic [15:0] m,
                                         input bit b);
        return {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000)
             ^ {15'b0, b};
    endfunction

    function automatic obs_t mk(input logic se, input logic ce,
                                input logic busy, input logic si,
                                input logic done);
        obs_t o;
        o.se = se; o.ce = ce; o.busy = busy; o.si = si; o.done = done;
        return o;
    endfunction

    // mode 0: scan_so all 0, mode 1: all 1, else seeded pseudo-random
    task automatic build(input int n, input int mode);
        logic [15:0] p;
        logic [15:0] m;
        logic [31:0] r;
        bit          b;
        p = 16'hACE1;
        m = 16'h0000;
        r = 32'(mode);
        exp_q.delete();
        so_q.delete();
        for (int k = 0; k < n; k++) begin
            for (int s = 0; s < CL; s++) begin
                r = r * 32'd1103515245 + 32'd12345;
                b = (mode == 1) ? 1'b1 : (mode == 0) ? 1'b0 : r[16];
                so_q.push_back(b);
                exp_q.push_back(mk(1, 1, 1, p[0], 0));
                if (k != 0) m = misr(m, b);
                p = lfsr(p);
            end
            for (int c = 0; c < CC; c++) begin
                so_q.push_back(mode == 1);
                exp_q.push_back(mk(0, 1, 1, p[0], 0));
            end
        end
        if (n != 0) begin
            for (int s = 0; s < CL; s++) begin
                r = r * 32'd1103515245 + 32'd12345;
                b = (mode == 1) ? 1'b1 : (mode == 0) ? 1'b0 : r[16];
                so_q.push_back(b);
                exp_q.push_back(mk(1, 1, 1, p[0], 0));
                m = misr(m, b);
                p = lfsr(p);
            end
        end
        so_q.push_back(1'b0);
        exp_q.push_back(mk(0, 0, 0, 0, 1));
        sig_exp = m;
    endtask

    task automatic run(input int n, input int mode,
                       output logic [15:0] sig_got,
                       output int busy_cnt,
                       output logic [3:0] first_si);
        obs_t e;
        obs_t g;
        int   k;
        build(n, mode);
        bus.num_pat = PW'(n);
        bus.start   = 1'b1;
        @(negedge CK);
        bus.start = 1'b0;
        k        = 0;
        busy_cnt = 0;
        first_si = '0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            bus.scan_so = so_q.pop_front();
            g = {bus.SE, bus.test_ce, bus.busy, bus.scan_si, bus.done};
            chk($sformatf("n%0d_cyc%0d", n, k), 32'(g), 32'(e));
            if (g.busy) busy_cnt++;
            if (k < 4) first_si[k] = bus.scan_si;
            k++;
            if (exp_q.size() > 0) @(negedge CK);
        end
        chk($sformatf("n%0d_sig", n), 32'(bus.signature), 32'(sig_exp));
        chk($sformatf("n%0d_pat", n), 32'(bus.pat_cnt), 32'(n));
        sig_got = bus.signature;
        @(negedge CK);
        chk("post_done", 32'(bus.done), 0);
    endtask

    logic [15:0] sg;
    int          bc;
    logic [3:0]  fs;

    initial begin
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.num_pat = '0;
        bus.scan_so = 1'b0;
        RN = 1'b0;
        repeat (2) @(negedge CK);
        chk("rst_out", 32'({bus.SE, bus.test_ce, bus.scan_si,
                            bus.busy, bus.done}), 0);
        chk("rst_pat", 32'(bus.pat_cnt), 0);
        chk("rst_sig", 32'(bus.signature), 0);
        RN = 1'b1;
        @(negedge CK);

        run(2, 5, sg, bc, fs);
        chk("busy_len", 32'(bc), 14);
        chk("si_first4", 32'(fs), 32'b0001);

        run(1, 1, sg, bc, fs);
        chk("sig_ones", 32'(sg), 32'h000F);

        run(0, 3, sg, bc, fs);
        chk("empty_sig", 32'(sg), 0);
        chk("empty_busy", 32'(bc), 0);

        bus.num_pat = PW'(2);
        bus.start   = 1'b1;
        bus.abort   = 1'b1;
        @(negedge CK);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("abort_wins", 32'({bus.busy, bus.SE, bus.done}), 0);

        run(2, 9, sg, bc, fs);
        bus.start = 1'b1;
        @(negedge CK);
        bus.start = 1'b0;
        @(negedge CK);
        bus.abort = 1'b1;
        @(negedge CK);
        bus.abort = 1'b0;
        chk("abort_out", 32'({bus.busy, bus.SE, bus.test_ce,
                              bus.done}), 0);
        chk("abort_pat", 32'(bus.pat_cnt), 0);
        @(negedge CK);
        chk("abort_nodone", 32'({bus.busy, bus.done}), 0);
        run(2, 5, sg, bc, fs);
        chk("restart_len", 32'(bc), 14);

        build(2, 7);
        bus.num_pat = PW'(2);
        bus.start   = 1'b1;
        @(negedge CK);
        bus.start = 1'b0;
        for (int i = 1; i < 10; i++) begin
            bus.scan_so = so_q.pop_front();
            @(negedge CK);
        end
        chk("in_capture", 32'({bus.SE, bus.test_ce, bus.busy}), 32'b011);
        chk("pre_rst_pat", 32'(bus.pat_cnt), 1);
        RN = 1'b0;
        #1;
        chk("rst_mid_out", 32'({bus.SE, bus.test_ce, bus.scan_si,
                                bus.busy, bus.done}), 0);
        chk("rst_mid_pat", 32'(bus.pat_cnt), 0);
        chk("rst_mid_sig", 32'(bus.signature), 0);
        @(negedge CK);
        RN = 1'b1;
        run(2, 7, sg, bc, fs);
        chk("post_rst_len", 32'(bc), 14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
